// File: rtl/hcsr04_emulator.sv
// HC-SR04 ultrasonic sensor emulator.
// Measures the trigger pulse width. After a valid trigger it waits a fixed
// delay, then drives an echo pulse whose width encodes the simulated distance:
// distancia * CICLOS_POR_CM cycles, or CICLOS_TIMEOUT cycles when distancia is 0.
// A dead time follows each echo before a new trigger is accepted.
module hcsr04_emulator #(
    parameter int CICLOS_TRIGGER_MIN = 500,
    parameter int CICLOS_ATRASO      = 10000,
    parameter int CICLOS_POR_CM      = 2941,
    parameter int CICLOS_TIMEOUT     = 1900000,
    parameter int CICLOS_RECUPERA    = 3000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic [11:0] distancia,
    output logic        echo,
    output logic        ocupado,
    output logic [3:0]  db_estado
);

    // The delay, timeout and dead-time phases never overlap, so they share
    // one counter sized for the longest of the three.
    localparam int CNT_MAX_AT = (CICLOS_ATRASO > CICLOS_TIMEOUT) ? CICLOS_ATRASO : CICLOS_TIMEOUT;
    localparam int CNT_MAX    = (CNT_MAX_AT > CICLOS_RECUPERA) ? CNT_MAX_AT : CICLOS_RECUPERA;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int TRG_W      = $clog2(CICLOS_TRIGGER_MIN + 1);
    localparam int SUB_W      = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;

    localparam logic [TRG_W-1:0] TRG_MIN     = TRG_W'(CICLOS_TRIGGER_MIN);
    localparam logic [CNT_W-1:0] ATRASO_FIM  = CNT_W'(CICLOS_ATRASO - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_FIM = CNT_W'(CICLOS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RECUPERA_FIM = CNT_W'(CICLOS_RECUPERA - 1);
    localparam logic [SUB_W-1:0] SUB_FIM     = SUB_W'(CICLOS_POR_CM - 1);

    typedef enum logic [3:0] {
        st_inicial      = 4'd0,
        st_mede_trigger = 4'd1,
        st_atraso       = 4'd2,
        st_echo_alto    = 4'd3,
        st_recupera     = 4'd4
    } estado_t;

    estado_t          estado;
    logic [TRG_W-1:0] cnt_trg;   // trigger width, saturates at the minimum
    logic [CNT_W-1:0] cnt;       // shared delay / timeout / dead-time counter
    logic [11:0]      cnt_cm;    // whole centimetres of echo elapsed
    logic [SUB_W-1:0] cnt_sub;   // cycles within the current centimetre
    logic [11:0]      dist_lat;  // distance captured at the trigger falling edge

    // Main FSM: all state, counters and the echo output move together.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= st_inicial;
            echo     <= 1'b0;
            cnt_trg  <= '0;
            cnt      <= '0;
            cnt_cm   <= '0;
            cnt_sub  <= '0;
            dist_lat <= '0;
        end else begin
            case (estado)
                st_inicial: begin
                    echo <= 1'b0;
                    if (trigger) begin
                        estado  <= st_mede_trigger;
                        cnt_trg <= TRG_W'(1);
                    end
                end
                st_mede_trigger: begin
                    if (trigger) begin
                        if (cnt_trg < TRG_MIN)
                            cnt_trg <= cnt_trg + TRG_W'(1);
                    end else if (cnt_trg >= TRG_MIN) begin
                        dist_lat <= distancia;
                        cnt      <= '0;
                        estado   <= st_atraso;
                    end else begin
                        estado <= st_inicial;
                    end
                end
                st_atraso: begin
                    if (cnt == ATRASO_FIM) begin
                        estado  <= st_echo_alto;
                        echo    <= 1'b1;
                        cnt     <= '0;
                        cnt_cm  <= '0;
                        cnt_sub <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                st_echo_alto: begin
                    if (dist_lat == 12'd0) begin
                        // Out of range: fixed-width timeout echo.
                        if (cnt == TIMEOUT_FIM) begin
                            estado <= st_recupera;
                            echo   <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (cnt_sub == SUB_FIM) begin
                        // One centimetre done; stop after the last one.
                        cnt_sub <= '0;
                        if (cnt_cm == dist_lat - 12'd1) begin
                            estado <= st_recupera;
                            echo   <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            cnt_cm <= cnt_cm + 12'd1;
                        end
                    end else begin
                        cnt_sub <= cnt_sub + SUB_W'(1);
                    end
                end
                st_recupera: begin
                    echo <= 1'b0;
                    if (cnt == RECUPERA_FIM) begin
                        estado <= st_inicial;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    estado <= st_inicial;
                    echo   <= 1'b0;
                end
            endcase
        end
    end

    assign ocupado   = (estado != st_inicial);
    assign db_estado = estado;

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Randomized scoreboard bench for hcsr04_emulator.
// The model predicts, per trigger attempt, the edge at which echo rises, its
// width, and the edge at which ocupado drops; a monitor compares observed
// pulses against those predictions in order.
module tb_hcsr04_emulator;

    localparam int MIN = 5;
    localparam int ATR = 10;
    localparam int PCM = 4;
    localparam int TO  = 100;
    localparam int REC = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        trigger;
    logic [11:0] distancia;
    logic        echo;
    logic        ocupado;
    logic [3:0]  db_estado;

    hcsr04_emulator #(
        .CICLOS_TRIGGER_MIN(MIN),
        .CICLOS_ATRASO(ATR),
        .CICLOS_POR_CM(PCM),
        .CICLOS_TIMEOUT(TO),
        .CICLOS_RECUPERA(REC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .trigger(trigger),
        .distancia(distancia),
        .echo(echo),
        .ocupado(ocupado),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Number of rising edges seen so far; sampled on falling edges.
    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    typedef struct {
        int rise;
        int width;
    } echo_t;

    echo_t exp_echo[$];
    int    exp_free[$];
    int    n_pass = 0;
    int    n_tot  = 0;
    int    idle   = 0;   // model: edge at which the emulator is back in inicial

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clock);
    endtask

    // Raise trigger now, hold it for n falling edges, and predict the outcome.
    task automatic trig(input int n, input int d, input bit push_echo,
                        output int r, output int w);
        int k, s, nn;
        k = edge_n;
        distancia = 12'(d);
        trigger = 1'b1;
        s  = (k + 1 > idle + 1) ? k + 1 : idle + 1;
        nn = k + n - s + 1;
        if (nn >= MIN) begin
            r = s + nn + ATR;
            w = (d == 0) ? TO : d * PCM;
            if (push_echo) begin
                exp_echo.push_back('{r, w});
                exp_free.push_back(r + w + REC);
            end
            idle = r + w + REC;
        end else begin
            r = -1;
            w = 0;
            exp_free.push_back(s + nn);
            idle = s + nn;
        end
        repeat (n) @(negedge clock);
        trigger = 1'b0;
    endtask

    // Monitor: pop a prediction on every echo fall and every ocupado fall.
    logic pe = 1'b0, po = 1'b0;
    int   rise_at = 0;
    always @(negedge clock) begin
        echo_t e;
        if (echo === 1'b1 && !pe) rise_at = edge_n;
        if (echo !== 1'b1 && pe) begin
            if (exp_echo.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_echo: rise %0d width %0d, none expected",
                         rise_at, edge_n - rise_at);
            end else begin
                e = exp_echo.pop_front();
                chk("echo_rise", rise_at, e.rise);
                chk("echo_width", edge_n - rise_at, e.width);
            end
        end
        if (ocupado !== 1'b1 && po) begin
            if (exp_free.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_idle: ocupado fell at %0d, none expected", edge_n);
            end else begin
                chk("ocupado_fall", edge_n, exp_free.pop_front());
            end
        end
        pe = (echo === 1'b1);
        po = (ocupado === 1'b1);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r, w, n, d;
        reset = 1'b1;
        trigger = 1'b0;
        distancia = '0;
        repeat (3) @(negedge clock);
        chk("reset_echo", int'(echo), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        chk("reset_estado", int'(db_estado), 0);
        reset = 1'b0;
        idle = edge_n;

        // Nominal measurement.
        trig(5, 7, 1, r, w);
        wait_edge(idle + 2);
        // Too-short trigger: no echo, ocupado drops on the low sample.
        trig(4, 7, 1, r, w);
        wait_edge(idle + 1);
        // Out of range.
        trig(5, 0, 1, r, w);
        wait_edge(idle + 3);
        // Distance change during delay and retrigger during echo are ignored.
        trig(5, 7, 1, r, w);
        wait_edge(r - 5);
        distancia = 12'd3;
        wait_edge(r + 3);
        trigger = 1'b1;
        repeat (6) @(negedge clock);
        trigger = 1'b0;
        wait_edge(idle + 2);

        // Reset five cycles into the echo.
        trig(5, 7, 0, r, w);
        exp_echo.push_back('{r, 5});
        exp_free.push_back(r + 5);
        idle = r + 5;
        wait_edge(r + 4);
        reset = 1'b1;
        @(negedge clock);
        chk("midecho_reset_echo", int'(echo), 0);
        chk("midecho_reset_ocupado", int'(ocupado), 0);
        chk("midecho_reset_estado", int'(db_estado), 0);
        reset = 1'b0;
        trig(6, 2, 1, r, w);

        // Trigger raised during dead time and held across its end.
        wait_edge(idle - 3);
        trig(10, 5, 1, r, w);

        // Randomized attempts with noise while busy.
        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(3, 8);
            d = $urandom_range(0, 30);
            wait_edge(idle + $urandom_range(0, 4));
            trig(n, d, 1, r, w);
            if (r >= 0) begin
                wait_edge(r);
                distancia = 12'($urandom_range(0, 4095));
                if ($urandom_range(0, 1) == 1) begin
                    wait_edge(r + $urandom_range(0, w / 2));
                    trigger = 1'b1;
                    repeat ($urandom_range(1, 6)) @(negedge clock);
                    trigger = 1'b0;
                end
            end
        end

        // Largest distance: full-width count without wrap.
        wait_edge(idle + 1);
        trig(5, 4095, 1, r, w);
        wait_edge(idle + 3);

        chk("echo_queue_empty", exp_echo.size(), 0);
        chk("idle_queue_empty", exp_free.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/hcsr04_emulator.md
HCSR04_EMULATOR -- requirements
Module: hcsr04_emulator

Interface
REQ-001 The block SHALL have parameter CICLOS_TRIGGER_MIN, default 500, the minimum trigger high width in cycles (10 us at 50 MHz).
REQ-002 The block SHALL have parameter CICLOS_ATRASO, default 10000, the delay in cycles from the trigger falling edge to echo rise.
REQ-003 The block SHALL have parameter CICLOS_POR_CM, default 2941, the echo cycles per centimetre (58.82 us at 50 MHz).
REQ-004 The block SHALL have parameter CICLOS_TIMEOUT, default 1900000, the echo width in cycles for out-of-range (38 ms).
REQ-005 The block SHALL have parameter CICLOS_RECUPERA, default 3000000, the dead time in cycles after echo falls before a new trigger is accepted.
REQ-006 The block SHALL have port clock, input, 1 bit, the single clock; all logic SHALL be clocked on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port trigger, input, 1 bit, the trigger pulse from the sensor interface under test, already synchronous to clock.
REQ-009 The block SHALL have port distancia, input, 12 bits, the simulated distance in cm; a value of 0 SHALL mean out-of-range.
REQ-010 The block SHALL have port echo, output, 1 bit, the emulated echo pulse, registered.
REQ-011 The block SHALL have port ocupado, output, 1 bit, which SHALL be high in every state except inicial.
REQ-012 The block SHALL have port db_estado, output, 4 bits, the encoded FSM state for debug.

Function
REQ-013 The FSM SHALL have the states inicial(0), mede_trigger(1), atraso(2), echo_alto(3), recupera(4), encoded as shown in db_estado.
REQ-014 In inicial, trigger=1 SHALL move the FSM to mede_trigger and set the width counter to 1.
REQ-015 In mede_trigger, trigger=1 SHALL increment the width counter, saturating at CICLOS_TRIGGER_MIN.
REQ-016 In mede_trigger, trigger=0 with counter >= CICLOS_TRIGGER_MIN SHALL latch distancia, clear the delay counter and move the FSM to atraso.
REQ-017 In mede_trigger, trigger=0 with counter < CICLOS_TRIGGER_MIN SHALL return the FSM to inicial without generating echo.
REQ-018 Echo SHALL go high exactly CICLOS_ATRASO clock edges after the edge at which trigger was first sampled low (REQ-016).
REQ-019 In echo_alto with latched distance D>0, echo SHALL stay high for exactly D*CICLOS_POR_CM cycles.
REQ-020 The echo width in REQ-019 SHALL be counted with a cm counter (12 bit) plus a sub-counter (ceil(log2(CICLOS_POR_CM)) bits), with no multiplier.
REQ-021 In echo_alto with latched D=0, echo SHALL stay high for exactly CICLOS_TIMEOUT cycles.
REQ-022 Echo SHALL fall on the same edge at which the FSM enters recupera.
REQ-023 In recupera, echo SHALL be 0 and the FSM SHALL count CICLOS_RECUPERA cycles, then enter inicial.
REQ-024 Trigger activity in atraso, echo_alto or recupera SHALL be ignored, with no restart and no queueing.
REQ-025 A trigger held high across the end of recupera SHALL be treated as a new rising edge in inicial.
REQ-026 A change of distancia after the latch in REQ-016 SHALL NOT affect the current echo.
REQ-027 All counter widths SHALL be derived from the parameters; no counter SHALL wrap within a measurement.

Reset
REQ-028 Reset=1 sampled at any edge, including mid-echo, SHALL force state inicial and echo=0, ocupado=0, db_estado=0 on that edge.
REQ-029 Reset SHALL clear all counters and the distance latch.
REQ-030 The first trigger sample SHALL be taken on the edge following reset deassertion.

Verification
The bench SHALL use CICLOS_TRIGGER_MIN=5, ATRASO=10, POR_CM=4, TIMEOUT=100, RECUPERA=20.
REQ-031 Trigger high 5 cycles, distancia=7 -> echo rises 10 cycles after trigger falls, width 28 cycles, ocupado low 20 cycles after echo falls.
REQ-032 Trigger high 4 cycles -> no echo; ocupado returns to 0 one cycle after trigger falls.
REQ-033 distancia=0, valid trigger -> echo width 100 cycles.
REQ-034 distancia changed 7->3 during atraso, plus a second valid trigger during echo_alto -> single echo of 28 cycles.
REQ-035 Reset pulsed 5 cycles into echo_alto -> echo=0 and db_estado=0 on the reset edge; the next valid trigger produces a normal echo.
REQ-036 distancia=4095 -> echo width 16380 cycles, checked exactly (the no-wrap check).
